// File: rtl/spi_ram_responder.sv
// SPI mode-0 serial-RAM target (READ 0x03 / WRITE 0x02, 16-bit address) backed by a byte array.
// Optional mode register (WRMR 0x01 / RDMR 0x05) enabled by SPI_RAM_RESPONDER_MODE_REG_EN.
module spi_ram_responder #(
    parameter int unsigned ADDR_BITS = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic spi_clk,
    input  logic spi_mosi,
    output logic spi_miso,
    input  logic spi_ce_n,
    output logic active,
    output logic bad_cmd
);

    localparam int unsigned DEPTH     = 2 ** ADDR_BITS;
    localparam logic [7:0]  CMD_WRITE = 8'h02;
    localparam logic [7:0]  CMD_READ  = 8'h03;
`ifdef SPI_RAM_RESPONDER_MODE_REG_EN
    localparam logic [7:0]  CMD_WRMR  = 8'h01;
    localparam logic [7:0]  CMD_RDMR  = 8'h05;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StWrData,
        StRdData,
        StIgnore
    } state_e;

    state_e                 state_q, state_d;
    logic [2:0]             sclk_sync_q;
    logic [1:0]             mosi_sync_q;
    logic [1:0]             ce_n_sync_q;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [7:0]             cmd_q, cmd_d;
    logic [7:0]             rd_byte_q, rd_byte_d;
    logic [2:0]             idx_q, idx_d;
    logic                   miso_q, miso_d;
    logic                   bad_cmd_q, bad_cmd_d;
    logic                   mem_we;
    logic [7:0]             mem [DEPTH];
`ifdef SPI_RAM_RESPONDER_MODE_REG_EN
    logic [7:0]             mode_q, mode_d;
`endif

    logic                   sclk_rise, sclk_fall, mosi_s, ce_n_s;
    logic [7:0]             shift_in;
    logic [ADDR_BITS-1:0]   addr_in, addr_inc;

    assign mosi_s    = mosi_sync_q[1];
    assign ce_n_s    = ce_n_sync_q[1];
    // Third copy of spi_clk gives the previous synchronized level for edge detection.
    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign shift_in  = {shift_q[6:0], mosi_s};
    assign addr_in   = {addr_q[ADDR_BITS-2:0], mosi_s};
    assign addr_inc  = addr_q + 1'b1;

    assign spi_miso  = miso_q;
    assign bad_cmd   = bad_cmd_q;
    assign active    = (state_q != StIdle) && !ce_n_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= 3'b000;
            mosi_sync_q <= 2'b00;
            ce_n_sync_q <= 2'b11;
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            addr_q      <= '0;
            cmd_q       <= '0;
            rd_byte_q   <= '0;
            idx_q       <= '0;
            miso_q      <= 1'b0;
            bad_cmd_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], spi_clk};
            mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
            ce_n_sync_q <= {ce_n_sync_q[0], spi_ce_n};
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            addr_q      <= addr_d;
            cmd_q       <= cmd_d;
            rd_byte_q   <= rd_byte_d;
            idx_q       <= idx_d;
            miso_q      <= miso_d;
            bad_cmd_q   <= bad_cmd_d;
        end
    end

`ifdef SPI_RAM_RESPONDER_MODE_REG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 8'h40;
        end else begin
            mode_q <= mode_d;
        end
    end
`endif

    // Array contents survive reset, so the array has no reset branch.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q] <= shift_in;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        addr_d    = addr_q;
        cmd_d     = cmd_q;
        rd_byte_d = rd_byte_q;
        idx_d     = idx_q;
        miso_d    = miso_q;
        bad_cmd_d = 1'b0;
        mem_we    = 1'b0;
`ifdef SPI_RAM_RESPONDER_MODE_REG_EN
        mode_d    = mode_q;
`endif
        if (ce_n_s) begin
            // Deselect wins over any coincident edge; a partial write byte is dropped.
            state_d   = StIdle;
            bit_cnt_d = '0;
            miso_d    = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d   = StCmd;
                    bit_cnt_d = '0;
                    miso_d    = 1'b0;
                end
                StCmd: begin
                    if (sclk_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = '0;
                            cmd_d     = shift_in;
                            case (shift_in)
                                CMD_WRITE, CMD_READ: state_d = StAddr;
`ifdef SPI_RAM_RESPONDER_MODE_REG_EN
                                CMD_WRMR: state_d = StWrData;
                                CMD_RDMR: begin
                                    state_d   = StRdData;
                                    rd_byte_d = mode_q;
                                    idx_d     = '0;
                                end
`endif
                                default: begin
                                    bad_cmd_d = 1'b1;
                                    state_d   = StIgnore;
                                end
                            endcase
                        end
                    end
                end
                StAddr: begin
                    if (sclk_rise) begin
                        addr_d    = addr_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd15) begin
                            bit_cnt_d = '0;
                            if (cmd_q == CMD_READ) begin
                                // Prefetch the first byte so MISO is ready on the next fall.
                                rd_byte_d = mem[addr_in];
                                addr_d    = addr_in + 1'b1;
                                idx_d     = '0;
                                state_d   = StRdData;
                            end else begin
                                state_d   = StWrData;
                            end
                        end
                    end
                end
                StWrData: begin
                    if (sclk_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = '0;
`ifdef SPI_RAM_RESPONDER_MODE_REG_EN
                            if (cmd_q == CMD_WRMR) begin
                                mode_d  = shift_in;
                                state_d = StIgnore;
                            end else begin
                                mem_we  = 1'b1;
                                addr_d  = addr_inc;
                            end
`else
                            mem_we = 1'b1;
                            addr_d = addr_inc;
`endif
                        end
                    end
                end
                StRdData: begin
                    if (sclk_fall) begin
                        miso_d = rd_byte_q[3'd7 - idx_q];
                        if (idx_q == 3'd7) begin
                            idx_d = '0;
`ifdef SPI_RAM_RESPONDER_MODE_REG_EN
                            if (cmd_q == CMD_RDMR) begin
                                rd_byte_d = mode_q;
                            end else begin
                                rd_byte_d = mem[addr_q];
                                addr_d    = addr_inc;
                            end
`else
                            rd_byte_d = mem[addr_q];
                            addr_d    = addr_inc;
`endif
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end
                end
                StIgnore: begin
                    miso_d = 1'b0;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

endmodule
